// File: rtl/exec_unit_seq.sv
// Sequential execution unit: 32 x DW register file, single-issue ALU with an
// iterative (or single-cycle) unsigned multiplier writing the high half to SGPR.
module exec_unit_seq #(
  parameter int DW       = 16,
  parameter int IMM_SEXT = 0,
  parameter int FAST_MUL = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   instr,
  input  logic          instr_valid,
  output logic          instr_ready,
  output logic          busy,
  output logic          done,
  output logic          illegal,
  output logic [4:0]    flags,
  output logic [DW-1:0] sgpr,
  input  logic [4:0]    dbg_addr,
  output logic [DW-1:0] dbg_data
);

  // state | meaning
  // IDLE  | waiting for an instruction, instr_ready=1
  // EXEC  | single-cycle result write, flag update, done pulse
  // MUL   | shift-add multiply, one multiplier bit per cycle
  typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;

  localparam logic [4:0] OP_MOVSGPR = 5'd0;
  localparam logic [4:0] OP_MOV     = 5'd1;
  localparam logic [4:0] OP_ADD     = 5'd2;
  localparam logic [4:0] OP_SUB     = 5'd3;
  localparam logic [4:0] OP_MUL     = 5'd4;
  localparam logic [4:0] OP_AND     = 5'd5;
  localparam logic [4:0] OP_OR      = 5'd6;
  localparam logic [4:0] OP_NOT     = 5'd7;
  localparam logic [4:0] OP_NAND    = 5'd8;
  localparam logic [4:0] OP_NOR     = 5'd9;
  localparam logic [4:0] OP_XOR     = 5'd10;
  localparam logic [4:0] OP_XNOR    = 5'd11;

  state_t state, state_nxt;

  logic [DW-1:0]   gpr [32];
  logic [4:0]      ir_op, ir_rdst;
  logic            ir_imm_mode;
  logic [DW-1:0]   op_a, op_b;
  logic [2*DW-1:0] prod;
  logic [5:0]      cnt;

  logic [4:0]      f_op, f_rdst, f_rs1, f_rs2;
  logic            f_imm_mode;
  logic [DW-1:0]   imm_ext, b_sel;

  logic            accept, exec_wr, mul_wr, done_nxt, illegal_nxt, legal;
  logic [DW-1:0]   res;
  logic            cout, ovf;
  logic [4:0]      flags_exec;
  logic [2*DW-1:0] prod_fast, prod_nxt;
  logic [DW:0]     step_sum;

  assign f_op       = instr[31:27];
  assign f_rdst     = instr[26:22];
  assign f_rs1      = instr[21:17];
  assign f_imm_mode = instr[16];
  assign f_rs2      = instr[15:11];

  // Immediate widening: bits above 15 come from the sign bit or zero.
  always_comb begin
    imm_ext = '0;
    for (int i = 0; i < DW; i++) begin
      if (i < 16) imm_ext[i] = instr[i];
      else        imm_ext[i] = (IMM_SEXT != 0) ? instr[15] : 1'b0;
    end
  end

  assign b_sel = f_imm_mode ? imm_ext : gpr[f_rs2];

  assign prod_fast = (2*DW)'(op_a) * (2*DW)'(op_b);

  // One shift-add step: conditionally add multiplicand into the upper half, shift right.
  assign step_sum = {1'b0, prod[2*DW-1:DW]} + {1'b0, (prod[0] ? op_a : {DW{1'b0}})};
  assign prod_nxt = {step_sum, prod[DW-1:1]};

  assign legal = (ir_op <= OP_XNOR);

  always_comb begin
    res  = '0;
    cout = 1'b0;
    ovf  = 1'b0;
    case (ir_op)
      OP_MOVSGPR: res = sgpr;
      OP_MOV:     res = op_b;
      OP_ADD: begin
        {cout, res} = {1'b0, op_a} + {1'b0, op_b};
        ovf = (op_a[DW-1] == op_b[DW-1]) && (res[DW-1] != op_a[DW-1]);
      end
      OP_SUB: begin
        res  = op_a - op_b;
        cout = (op_a < op_b);
        ovf  = (op_a[DW-1] != op_b[DW-1]) && (res[DW-1] != op_a[DW-1]);
      end
      OP_MUL:  res = prod_fast[DW-1:0];
      OP_AND:  res = op_a & op_b;
      OP_OR:   res = op_a | op_b;
      OP_NOT:  res = ir_imm_mode ? ~op_b : ~op_a;
      OP_NAND: res = ~(op_a & op_b);
      OP_NOR:  res = ~(op_a | op_b);
      OP_XOR:  res = op_a ^ op_b;
      OP_XNOR: res = ~(op_a ^ op_b);
      default: res = '0;
    endcase
    if (ir_op == OP_MUL)
      flags_exec = {prod_fast[2*DW-1], (prod_fast == '0), 1'b0, 1'b0, ~^res};
    else
      flags_exec = {res[DW-1], (res == '0), cout, ovf, ~^res};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    exec_wr     = 1'b0;
    mul_wr      = 1'b0;
    done_nxt    = 1'b0;
    illegal_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (instr_valid) begin
          accept    = 1'b1;
          state_nxt = (f_op == OP_MUL && FAST_MUL == 0) ? MUL : EXEC;
        end
      end
      EXEC: begin
        done_nxt    = 1'b1;
        illegal_nxt = ~legal;
        exec_wr     = legal;
        state_nxt   = IDLE;
      end
      MUL: begin
        if (cnt == 6'd0) begin
          done_nxt  = 1'b1;
          mul_wr    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign instr_ready = (state == IDLE);
  assign busy        = (state == EXEC) || (state == MUL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) gpr[i] <= '0;
      sgpr        <= '0;
      flags       <= '0;
      done        <= 1'b0;
      illegal     <= 1'b0;
      ir_op       <= '0;
      ir_rdst     <= '0;
      ir_imm_mode <= 1'b0;
      op_a        <= '0;
      op_b        <= '0;
      prod        <= '0;
      cnt         <= '0;
    end else begin
      done    <= done_nxt;
      illegal <= illegal_nxt;
      if (accept) begin
        ir_op       <= f_op;
        ir_rdst     <= f_rdst;
        ir_imm_mode <= f_imm_mode;
        op_a        <= gpr[f_rs1];
        op_b        <= b_sel;
        prod        <= {{DW{1'b0}}, b_sel};
        cnt         <= 6'(DW - 1);
      end
      if (state == MUL) begin
        prod <= prod_nxt;
        if (cnt != 6'd0) cnt <= cnt - 6'd1;
      end
      if (exec_wr) begin
        gpr[ir_rdst] <= res;
        flags        <= flags_exec;
        if (ir_op == OP_MUL) sgpr <= prod_fast[2*DW-1:DW];
      end
      if (mul_wr) begin
        gpr[ir_rdst] <= prod_nxt[DW-1:0];
        sgpr         <= prod_nxt[2*DW-1:DW];
        flags        <= {prod_nxt[2*DW-1], (prod_nxt == '0), 1'b0, 1'b0, ~^prod_nxt[DW-1:0]};
      end
    end
  end

  assign dbg_data = gpr[dbg_addr];

endmodule

// File: tb/tb_exec_unit_seq.sv
// Directed bench for exec_unit_seq (DW=16, zero-extended immediate, iterative multiply).
module tb_exec_unit_seq;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   instr;
  logic          instr_valid;
  logic          instr_ready, busy, done, illegal;
  logic [4:0]    flags;
  logic [DW-1:0] sgpr;
  logic [4:0]    dbg_addr;
  logic [DW-1:0] dbg_data;

  int tests  = 0;
  int failed = 0;

  exec_unit_seq #(.DW(DW), .IMM_SEXT(0), .FAST_MUL(0)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .busy(busy), .done(done), .illegal(illegal),
    .flags(flags), .sgpr(sgpr), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ei(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [15:0] imm);
    return {op, rd, rs1, 1'b1, imm};
  endfunction

  function automatic logic [31:0] er(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2);
    return {op, rd, rs1, 1'b0, rs2, 11'd0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [4:0] a, input logic [DW-1:0] exp);
    dbg_addr = a;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  // Issue one instruction and wait for retire; junk=1 also holds a stray
  // instr_valid (mov R12,#FFFF) while the unit is busy and checks ready stays low.
  task automatic run(input string tag, input logic [31:0] ins, input int exp_lat,
                     input logic exp_ill, input bit junk);
    int n;
    bit rdy_low;
    @(negedge clk);
    chk({tag, "_ready"}, instr_ready, 1);
    instr = ins;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    if (junk) begin
      instr = ei(5'd1, 5'd12, 5'd0, 16'hFFFF);
      instr_valid = 1'b1;
    end
    n = 0;
    rdy_low = 1'b1;
    while (!done && n < 40) begin
      if (instr_ready) rdy_low = 1'b0;
      @(negedge clk);
      n++;
    end
    instr_valid = 1'b0;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_illegal"}, illegal, exp_ill);
    if (junk) chk({tag, "_ready_low"}, rdy_low, 1);
  endtask

  initial begin
    bit saw_done;
    rst = 1'b1;
    instr = '0;
    instr_valid = 1'b0;
    dbg_addr = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready", instr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_flags", flags, 0);
    chk("rst_sgpr", sgpr, 0);
    chk("rst_done", done, 0);

    run("add1", ei(5'd2, 5'd1, 5'd0, 16'hFFFF), 1, 0, 0);
    chk_reg("add1_r1", 5'd1, 16'hFFFF);
    chk("add1_flags", flags, 5'b10001);

    run("add2", ei(5'd2, 5'd2, 5'd1, 16'h0001), 1, 0, 0);
    chk_reg("add2_r2", 5'd2, 16'h0000);
    chk("add2_flags", flags, 5'b01101);

    run("mov3", ei(5'd1, 5'd3, 5'd0, 16'h7FFF), 1, 0, 0);
    chk_reg("mov3_r3", 5'd3, 16'h7FFF);

    run("addov", ei(5'd2, 5'd4, 5'd3, 16'h0001), 1, 0, 0);
    chk_reg("addov_r4", 5'd4, 16'h8000);
    chk("addov_flags", flags, 5'b10010);

    run("sub", ei(5'd3, 5'd5, 5'd0, 16'h0001), 1, 0, 0);
    chk_reg("sub_r5", 5'd5, 16'hFFFF);
    chk("sub_flags", flags, 5'b10101);

    run("xor", er(5'd10, 5'd8, 5'd1, 5'd3), 1, 0, 0);
    chk_reg("xor_r8", 5'd8, 16'h8000);
    chk("xor_flags", flags, 5'b10000);

    run("addself", er(5'd2, 5'd3, 5'd3, 5'd3), 1, 0, 0);
    chk_reg("addself_r3", 5'd3, 16'hFFFE);
    chk("addself_flags", flags, 5'b10010);

    run("not", ei(5'd7, 5'd10, 5'd0, 16'h00FF), 1, 0, 0);
    chk_reg("not_r10", 5'd10, 16'hFF00);

    run("mov1", ei(5'd1, 5'd1, 5'd0, 16'h0100), 1, 0, 0);
    run("mul", ei(5'd4, 5'd6, 5'd1, 16'h0100), 16, 0, 1);
    chk_reg("mul_r6", 5'd6, 16'h0000);
    chk("mul_sgpr", sgpr, 16'h0001);
    chk("mul_flags", flags, 5'b00001);
    chk_reg("mul_r12_ignored", 5'd12, 16'h0000);

    run("movsgpr", ei(5'd0, 5'd11, 5'd0, 16'h0000), 1, 0, 0);
    chk_reg("movsgpr_r11", 5'd11, 16'h0001);

    run("mov7", ei(5'd1, 5'd7, 5'd0, 16'h1234), 1, 0, 0);
    run("sub2", ei(5'd3, 5'd5, 5'd0, 16'h0001), 1, 0, 0);
    run("ill", ei(5'd31, 5'd7, 5'd0, 16'hAAAA), 1, 1, 0);
    chk_reg("ill_r7", 5'd7, 16'h1234);
    chk("ill_flags", flags, 5'b10101);

    run("mov6", ei(5'd1, 5'd6, 5'd0, 16'h5555), 1, 0, 0);
    @(negedge clk);
    instr = ei(5'd4, 5'd6, 5'd1, 16'h0100);
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    saw_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("abort_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("abort_async_ready", instr_ready, 1);
    repeat (2) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("abort_no_done", saw_done, 0);
    chk("abort_sgpr", sgpr, 0);
    chk("abort_flags", flags, 0);
    chk("abort_ready", instr_ready, 1);
    for (int r = 0; r < 32; r++) chk_reg($sformatf("abort_r%0d", r), 5'(r), 16'h0000);

    run("post", ei(5'd1, 5'd2, 5'd0, 16'h00AB), 1, 0, 0);
    chk_reg("post_r2", 5'd2, 16'h00AB);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/exec_unit_seq.md
EXEC_UNIT_SEQ -- requirements
Module: exec_unit_seq

Interface
REQ-001 SHALL have parameter DW, default 16, meaning data/register width; legal range 8..32.
REQ-002 SHALL have parameter IMM_SEXT, default 0, meaning 0 zero-extends and 1 sign-extends the 16-bit immediate to DW; for DW<16 the immediate is truncated.
REQ-003 SHALL have parameter FAST_MUL, default 0, meaning 0 uses an iterative shift-add multiply of DW cycles and 1 uses a single-cycle multiply.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 instr  input  32  instruction: [31:27] op, [26:22] rdst, [21:17] rsrc1, [16] imm mode, [15:11] rsrc2, [15:0] imm.
REQ-007 instr_valid  input  1  instr is valid this cycle.
REQ-008 instr_ready  output  1  unit can accept an instruction.
REQ-009 busy  output  1  an instruction is in flight.
REQ-010 done  output  1  one-cycle pulse at instruction retire.
REQ-011 illegal  output  1  one-cycle pulse coincident with done for an undefined opcode.
REQ-012 flags  output  5  registered {sign, zero, carry, overflow, parity}.
REQ-013 sgpr  output  DW  special register holding the upper product half.
REQ-014 dbg_addr  input  5  register-file read address.
REQ-015 dbg_data  output  DW  combinational read of GPR[dbg_addr].

Function
REQ-016 SHALL contain 32 GPRs of DW bits plus SGPR, all written only on rising clk edges.
REQ-017 SHALL use the FSM states IDLE, EXEC and MUL; instr_ready=1 only in IDLE; busy=1 in EXEC and MUL.
REQ-018 SHALL accept an instruction on instr_valid&&instr_ready and latch IR, both operands and the extended immediate; next state is MUL when op=mul and FAST_MUL=0, otherwise EXEC.
REQ-019 SHALL, in EXEC, write the result, update flags, pulse done and return to IDLE, so non-iterative latency is 1 cycle after accept and throughput is one instruction per 2 cycles.
REQ-020 SHALL, in MUL, iterate exactly DW cycles on the latched operands, write the low product half to rdst and the high half to SGPR, pulse done and return to IDLE; done occurs DW cycles after accept.
REQ-021 SHALL use these opcodes: movsgpr 00000 (rdst=SGPR); mov 00001; add 00010; sub 00011; mul 00100 (unsigned); and 00101; or 00110; not 00111 (imm mode ~imm, else ~rsrc1); nand 01000; nor 01001; xor 01010; xnor 01011.
REQ-022 SHALL use operand B = extended imm when imm mode=1, else GPR[rsrc2].
REQ-023 SHALL treat opcodes 01100..11111 as illegal: no GPR/SGPR/flag write, done and illegal both pulse in EXEC.
REQ-024 carry SHALL be sum bit DW for add, borrow (A<B unsigned) for sub, and 0 otherwise.
REQ-025 overflow SHALL be set for add when A and B have equal MSBs and the result MSB differs from them, for sub when A and B MSBs differ and the result MSB differs from A, and SHALL be 0 otherwise.
REQ-026 zero SHALL be result==0, except for mul where it is set when the full 2*DW product is 0.
REQ-027 sign SHALL be the result MSB, except for mul where it is the product bit 2*DW-1.
REQ-028 parity SHALL be 1 when the result has an even number of ones (for mul, the low half).
REQ-029 rdst equal to rsrc1 or rsrc2 SHALL be safe, because operands are latched at accept.
REQ-030 instr_valid SHALL be ignored while instr_ready=0; no queueing.

Reset
REQ-031 rst SHALL clear all GPRs, SGPR, flags, done, illegal and the multiply datapath, and SHALL force IDLE, asynchronously.
REQ-032 rst asserted during EXEC or MUL SHALL abort the instruction: no register write and no done pulse.
REQ-033 After rst deasserts, instr_ready SHALL be 1 on the first clk edge.

Verification (DW=16, IMM_SEXT=0)
REQ-034 Reset: apply rst mid-run -> all GPRs read 0 via dbg, sgpr=0, flags=0, instr_ready=1.
REQ-035 Add carry: add R1,R0,#FFFF, then add R2,R1,#0001 -> R2=0000 with carry=1, zero=1, overflow=0, parity=1.
REQ-036 Overflow and sub: R3=7FFF, then add R4,R3,#0001 -> 8000 with overflow=1, sign=1; then sub R5,R0,#0001 -> FFFF with carry=1, sign=1.
REQ-037 Iterative mul: R1=0100, then mul R6,R1,#0100 -> R6=0000, sgpr=0001, zero=0; done exactly 16 cycles after accept; instr_ready=0 throughout.
REQ-038 Abort: assert rst 5 cycles into the mul -> R6 and sgpr are 0, no done, and the next instruction is accepted normally.
REQ-039 Illegal: op 11111 with R7 preloaded to 1234 -> done and illegal pulse together, R7 and flags unchanged.
